serial_scan_ctrl: RTL

SERIAL_SCAN_CTRL -- requirements
Module: serial_scan_ctrl

---
 rtl/serial_scan_ctrl_pkg.sv | 15 +
 rtl/serial_scan_ctrl_pair_det.sv | 29 ++
 rtl/serial_scan_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_scan_ctrl_pkg.sv
// Shared types and constants for the serial scan controller and its pair detector.
package serial_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    localparam int unsigned W_DEFAULT = 8;
    localparam int unsigned CNT_W     = 4;
    // W never exceeds 16, so W-1 always fits in four bits.
    localparam int unsigned IDX_W     = 4;

endpackage

// File: rtl/serial_scan_ctrl_pair_det.sv
// Two-consecutive-ones detector over a serial bit stream.
// The match output flags the current din completing a 1-1 pair.
module pair_det (
    input  logic ck,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic match
);

    logic prev_r;

    // Remembers the previously presented bit; cleared at the start of every word.
    always_ff @(posedge ck) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else if (clr) begin
            prev_r <= 1'b0;
        end else if (en) begin
            prev_r <= din;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign match = en & din & prev_r;

endmodule

// File: rtl/serial_scan_ctrl.sv
// Serial scan controller: shifts a captured word out MSB-first and counts
// overlapping pairs of consecutive ones, pulsing done after a fixed latency.
module serial_scan_ctrl
    import serial_scan_ctrl_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     word_in,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] count,
    output logic             bit_out
);

    scan_state_t      state_r;
    logic [W-1:0]     sr_r;
    logic [IDX_W-1:0] idx_r;
    logic [CNT_W-1:0] count_r;
    logic             hit_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             shift_en_s;
    logic             match_s;

    assign accept_s   = (state_r == IDLE) & start;
    assign shift_en_s = (state_r == SHIFT);

    pair_det u_pair_det (
        .ck    (ck),
        .rst   (rst),
        .clr   (accept_s),
        .en    (shift_en_s),
        .din   (sr_r[W-1]),
        .match (match_s)
    );

    // Scan sequencer: capture on accept, shift one bit per cycle, one-cycle DONE.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_r <= IDLE;
            sr_r    <= {W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            hit_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            hit_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sr_r    <= word_in;
                        idx_r   <= IDX_W'(W - 1);
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    // Zero fill leaves the register clear once the word is out,
                    // which keeps bit_out low back in IDLE.
                    sr_r <= {sr_r[W-2:0], 1'b0};
                    if (match_s) begin
                        count_r <= count_r + CNT_W'(1);
                        hit_r   <= 1'b1;
                    end else begin
                        count_r <= count_r;
                    end
                    if (idx_r == {IDX_W{1'b0}}) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r - IDX_W'(1);
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    sr_r    <= {W{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign hit     = hit_r;
    assign count   = count_r;
    assign bit_out = sr_r[W-1];

endmodule
